if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage: the producer side of the instruction/pc pair consumed by the decode stage.
- Owns the architectural PC and issues one read at a time to a variable-latency instruction memory port.
- Delivers fetched words through an IF/ID output register with a valid flag.
- Honours decode-side hazard freeze and EXE-side branch redirect/flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_WORD, 32'h0000_0000, instruction value driven while if_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- freeze  in  1  decode hazard; hold IF/ID contents and the PC.
- branch_taken  in  1  redirect request from EXE.
- branch_addr  in  32  redirect target.
- imem_req  out  1  read request.
- imem_addr  out  32  read address; word aligned.
- imem_ready  in  1  request accepted when imem_req && imem_ready.
- imem_rvalid  in  1  read data valid, at least 1 cycle after acceptance.
- imem_rdata  in  32  read data.
- if_pc  out  32  fetch address + PC_STEP of the presented instruction.
- if_instruction  out  32  presented instruction.
- if_valid  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_reg=RESET_PC; state=REQ; discard=0; hold buffer empty.
  - if_valid=0, if_instruction=NOP_WORD, if_pc=0.
  - imem_req=0 while rst=0.
- imem_addr=pc_reg at all times; bits [1:0] are always 0.
- FSM states:
  - REQ:
    - imem_req=1 when the hold buffer is empty, else 0.
    - On acceptance, go to WAIT.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid, return to REQ.
    - Response handling:
      - If discard=1, drop the data and clear discard.
      - Else if the IF/ID register may load, load it.
      - Else write the hold buffer.
    - pc_reg advances by PC_STEP on each non-discarded response, not on request.
- At most one outstanding request. imem_rvalid outside WAIT is ignored.
- IF/ID register loads when freeze=0:
  - Source is the hold buffer if full (buffer then empties), else a non-discarded response this cycle.
  - If no source exists, if_valid goes to 0 (bubble, NOP_WORD).
  - if_pc = address of the loaded word + PC_STEP.
- freeze=1:
  - if_pc, if_instruction and if_valid hold.
  - A response arriving goes to the hold buffer.
  - With the buffer full, no new request is issued.
- branch_taken=1 (priority over freeze and over any response that cycle):
  - pc_reg <= branch_addr; hold buffer emptied.
  - if_valid <= 0 next cycle.
  - If in WAIT with no rvalid this cycle, discard <= 1 and the FSM stays in WAIT.
  - If in REQ, a request accepted the same cycle is also marked discard; else the next request uses branch_addr.
- Flush latency: the first instruction from branch_addr appears at the earliest 2 cycles after branch_taken when memory has 1-cycle latency.
- Width rules:
  - PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
  - branch_addr bits [1:0] are forced to 0.
- Reset mid-transaction:
  - Any outstanding response is lost.
  - The FSM restarts cleanly at RESET_PC; late rvalid is ignored, since the state is REQ.

Test Plan:
- Reset release; memory with 1-cycle latency returning word=addr|0xA0000000 -> addresses 0,4,8 requested; if_instruction sequence A0000000, A0000004, A0000008 with if_pc 4, 8, 12; if_valid goes 1 on the cycle after the first rvalid.
- freeze=1 for 3 cycles after the word from addr 8 is presented -> IF/ID holds A0000008; the addr-C word sits in the buffer; no imem_req while the buffer is full; after release, A000000C is presented next with none skipped or duplicated.
- branch_taken with branch_addr=0x100 while in WAIT on addr 0x10 -> the 0x10 response is dropped; next request is 0x100; if_valid=0 for the bubble cycles; then A0000100 with if_pc=0x104.
- branch_taken and freeze asserted together -> branch wins: if_valid=0 next cycle, buffer emptied, fetch resumes at target.
- Memory latency of 4 cycles with imem_ready delayed 2 cycles -> imem_req stays high until accepted; exactly one outstanding request; if_valid bubbles between words.
- rst pulsed low during WAIT, then late rvalid -> outputs reset immediately; late data ignored; first request after release is RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage. Owns the architectural PC, issues one read at a
//   time to a variable-latency instruction memory and presents fetched words
//   to decode through an IF/ID register. A single-entry hold buffer absorbs a
//   response that arrives while decode is frozen. A branch redirect flushes
//   the stage and drops any response still in flight.
//
//   Ports
//     clk            rising-edge clock
//     rst            asynchronous reset, active low
//     freeze         decode hazard: hold IF/ID and the PC
//     branch_taken   redirect request from EXE
//     branch_addr    redirect target (bits [1:0] ignored)
//     imem_req       read request (accepted when imem_req && imem_ready)
//     imem_addr      read address, always pc_reg, word aligned
//     imem_ready     memory accepts the request
//     imem_rvalid    read data valid
//     imem_rdata     read data
//     if_pc          address of presented instruction + PC_STEP
//     if_instruction presented instruction (NOP_WORD when if_valid=0)
//     if_valid       IF/ID slot holds a real instruction
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_instruction,
   output logic        if_valid
);

   typedef enum logic {
      ST_REQ,
      ST_WAIT
   } state_t;

   state_t      state;
   logic [31:0] pc_reg;
   logic        discard;
   logic        hold_full;
   logic [31:0] hold_data;
   logic [31:0] hold_pc;

   logic        accept;
   logic        resp;
   logic        resp_keep;
   logic [31:0] pc_seq;
   logic [31:0] branch_target;

   // Request is gated by rst so nothing is issued while reset is asserted.
   assign imem_req      = rst && (state == ST_REQ) && !hold_full;
   assign imem_addr     = pc_reg;
   assign accept        = imem_req && imem_ready;
   assign resp          = (state == ST_WAIT) && imem_rvalid;
   // A redirect in the same cycle overrides any response.
   assign resp_keep     = resp && !discard && !branch_taken;
   assign pc_seq        = pc_reg + PC_STEP;
   assign branch_target = branch_addr & ~32'd3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_REQ;
         pc_reg         <= RESET_PC & ~32'd3;
         discard        <= 1'b0;
         hold_full      <= 1'b0;
         hold_data      <= '0;
         hold_pc        <= '0;
         if_pc          <= '0;
         if_instruction <= NOP_WORD;
         if_valid       <= 1'b0;
      end else if (branch_taken) begin
         pc_reg         <= branch_target;
         hold_full      <= 1'b0;
         if_valid       <= 1'b0;
         if_instruction <= NOP_WORD;
         case (state)
            ST_REQ: begin
               // A request accepted alongside the redirect fetches the old PC.
               if (accept) begin
                  state   <= ST_WAIT;
                  discard <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  state   <= ST_REQ;
                  discard <= 1'b0;
               end else begin
                  discard <= 1'b1;
               end
            end
            default: state <= ST_REQ;
         endcase
      end else begin
         case (state)
            ST_REQ: begin
               if (accept) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  state   <= ST_REQ;
                  discard <= 1'b0;
               end
            end
            default: state <= ST_REQ;
         endcase

         // PC advances on delivery, so pc_reg is the address of the word in flight.
         if (resp_keep) pc_reg <= pc_seq;

         if (!freeze) begin
            if (hold_full) begin
               if_instruction <= hold_data;
               if_pc          <= hold_pc;
               if_valid       <= 1'b1;
               hold_full      <= 1'b0;
            end else if (resp_keep) begin
               if_instruction <= imem_rdata;
               if_pc          <= pc_seq;
               if_valid       <= 1'b1;
            end else begin
               if_instruction <= NOP_WORD;
               if_valid       <= 1'b0;
            end
         end

         // Response that cannot go straight into IF/ID is parked; this
         // assignment must follow the buffer drain above so it takes effect.
         if (resp_keep && (freeze || hold_full)) begin
            hold_data <= imem_rdata;
            hold_pc   <= pc_seq;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        if_valid;

   always #5 clk = ~clk;

   if_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (32'd4),
      .NOP_WORD (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .branch_taken   (branch_taken),
      .branch_addr    (branch_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_pc          (if_pc),
      .if_instruction (if_instruction),
      .if_valid       (if_valid)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference: the presented stream must be exp_pc, exp_pc+4, ... restarting at each branch target.
   logic [31:0] exp_pc;
   int unsigned presented = 0;

   // Memory model state.
   bit          outstanding = 1'b0;
   int unsigned wait_cnt = 0;
   logic [31:0] mem_addr = '0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int unsigned ready_pct = 100;
   int unsigned ready_delay = 0;
   int unsigned req_age = 0;
   bit          accepted_last = 1'b0;
   logic [31:0] accept_addr_last = '0;
   int unsigned bubbles = 0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a | 32'hA000_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: starts and ends at a negedge.
   task automatic step(input bit fr, input bit br, input logic [31:0] ba);
      bit          acc;
      bit          rv;
      bit          must_load;
      logic [31:0] rv_addr;
      logic [31:0] p_pc;
      logic [31:0] p_ins;
      logic        p_v;
      logic        p_req;
      logic [31:0] req_addr;

      rv = 1'b0;
      rv_addr = '0;
      if (outstanding) begin
         if (wait_cnt <= 1) begin
            rv = 1'b1;
            rv_addr = mem_addr;
         end else begin
            wait_cnt--;
         end
      end
      imem_rvalid = rv;
      imem_rdata  = rv ? word_of(rv_addr) : $urandom;
      if (ready_delay > 0) imem_ready = imem_req && (req_age >= ready_delay);
      else                 imem_ready = ($urandom_range(99) < ready_pct);
      acc = imem_req && imem_ready;
      if (acc) req_age = 0;
      else if (imem_req) req_age++;

      chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (outstanding) chk("one_outstanding", {31'd0, imem_req}, 32'd0);

      freeze       = fr;
      branch_taken = br;
      branch_addr  = ba;
      must_load    = rv && !br && !fr && (rv_addr == exp_pc);
      p_pc  = if_pc;
      p_ins = if_instruction;
      p_v   = if_valid;
      p_req = imem_req;
      req_addr = imem_addr;

      @(posedge clk);
      if (rv) outstanding = 1'b0;
      if (acc) begin
         outstanding = 1'b1;
         wait_cnt    = $urandom_range(lat_max, lat_min);
         mem_addr    = req_addr;
      end
      accepted_last    = acc;
      accept_addr_last = req_addr;

      @(negedge clk);
      if (br) begin
         chk("branch_bubble", {31'd0, if_valid}, 32'd0);
         exp_pc = ba & ~32'd3;
      end else if (fr) begin
         chk("freeze_valid", {31'd0, if_valid}, {31'd0, p_v});
         chk("freeze_instr", if_instruction, p_ins);
         chk("freeze_pc", if_pc, p_pc);
      end else begin
         if (must_load) chk("load_on_response", {31'd0, if_valid}, 32'd1);
         if (if_valid) begin
            chk("stream_instr", if_instruction, word_of(exp_pc));
            chk("stream_pc", if_pc, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            presented++;
         end
      end
      if (p_req && !acc) chk("req_held_until_accept", {31'd0, imem_req}, 32'd1);
      if (!if_valid) bubbles++;
      branch_taken = 1'b0;
   endtask

   task automatic run_until_presented(input string tag, input int unsigned n, input int unsigned bound);
      int unsigned start;
      start = presented;
      for (int unsigned i = 0; i < bound && presented < start + n; i++) step(1'b0, 1'b0, '0);
      chk(tag, {31'd0, presented >= start + n}, 32'd1);
   endtask

   initial begin
      logic [31:0] region;
      int unsigned start;

      rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_valid", {31'd0, if_valid}, 32'd0);
      chk("reset_instr", if_instruction, 32'h0000_0000);
      chk("reset_pc", if_pc, 32'd0);
      chk("reset_req", {31'd0, imem_req}, 32'd0);
      chk("reset_addr", imem_addr, 32'd0);

      // Sequential fetch, 1-cycle memory.
      rst = 1'b1;
      exp_pc = 32'd0;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'd0);
      run_until_presented("timeout_first_words", 3, 30);
      chk("word8_instr", if_instruction, 32'hA000_0008);
      chk("word8_pc", if_pc, 32'd12);

      // Freeze for 3 cycles; the next word is parked in the hold buffer.
      for (int unsigned i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, '0);
         if (i >= 1) chk("no_req_buffer_full", {31'd0, imem_req}, 32'd0);
      end
      step(1'b0, 1'b0, '0);
      chk("after_freeze_instr", if_instruction, 32'hA000_000C);
      chk("after_freeze_valid", {31'd0, if_valid}, 32'd1);

      // Redirect while waiting on address 0x10.
      lat_min = 2; lat_max = 2;
      for (int unsigned i = 0; i < 20 && !(accepted_last && accept_addr_last == 32'h10); i++)
         step(1'b0, 1'b0, '0);
      chk("reach_wait_0x10", {31'd0, accepted_last && accept_addr_last == 32'h10}, 32'd1);
      step(1'b0, 1'b1, 32'h0000_0100);
      for (int unsigned i = 0; i < 20 && !accepted_last; i++) step(1'b0, 1'b0, '0);
      chk("req_after_branch", accept_addr_last, 32'h0000_0100);
      run_until_presented("timeout_target_word", 1, 30);
      chk("target_instr", if_instruction, 32'hA000_0100);
      chk("target_pc", if_pc, 32'h0000_0104);

      // Branch and freeze together; low address bits ignored.
      step(1'b1, 1'b1, 32'h0000_0203);
      run_until_presented("timeout_branch_freeze", 1, 40);
      chk("branch_freeze_instr", if_instruction, 32'hA000_0200);

      // PC wraps modulo 2^32.
      step(1'b0, 1'b1, 32'hFFFF_FFF9);
      run_until_presented("timeout_wrap", 3, 60);
      chk("wrap_instr", if_instruction, 32'hA000_0000);
      chk("wrap_pc", if_pc, 32'd4);

      // Slow memory: 4-cycle latency, ready two cycles late.
      lat_min = 4; lat_max = 4; ready_delay = 2; req_age = 0;
      bubbles = 0;
      start = presented;
      for (int unsigned i = 0; i < 40; i++) step(1'b0, 1'b0, '0);
      chk("slow_bubbles", {31'd0, bubbles > 10}, 32'd1);
      chk("slow_progress", {31'd0, presented > start}, 32'd1);

      // Randomized freeze / redirect / ready / latency.
      ready_delay = 0; ready_pct = 60; lat_min = 1; lat_max = 4;
      region = 32'h0001_0000;
      for (int unsigned i = 0; i < 400; i++) begin
         bit fr;
         bit br;
         fr = ($urandom_range(3) == 0);
         br = ($urandom_range(19) == 0);
         if (br) region = region + 32'h1000;
         step(fr, br, region | 32'($urandom_range(3)));
      end

      // Reset while a read is outstanding; late data must be ignored.
      ready_pct = 100; lat_min = 3; lat_max = 3;
      for (int unsigned i = 0; i < 20 && !outstanding; i++) step(1'b0, 1'b0, '0);
      chk("reach_outstanding", {31'd0, outstanding}, 32'd1);
      rst = 1'b0;
      #1;
      chk("async_reset_valid", {31'd0, if_valid}, 32'd0);
      chk("async_reset_instr", if_instruction, 32'h0000_0000);
      chk("async_reset_pc", if_pc, 32'd0);
      chk("async_reset_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      outstanding = 1'b0;
      rst = 1'b1;
      exp_pc = 32'd0;
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; imem_ready = 1'b0;
      freeze = 1'b0; branch_taken = 1'b0;
      #1;
      chk("restart_req", {31'd0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("late_rvalid_ignored", {31'd0, if_valid}, 32'd0);
      chk("late_rvalid_req", {31'd0, imem_req}, 32'd1);
      imem_rvalid = 1'b0;
      req_age = 0;
      run_until_presented("timeout_after_reset", 1, 20);
      chk("after_reset_instr", if_instruction, 32'hA000_0000);

      chk("stream_progress", {31'd0, presented >= 30}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
